// File: rtl/exp10_pkg.sv
// Shared definitions for the time-of-day controller: mode codes, BCD width, BCD helpers.
package exp10_pkg;

  localparam int BCD_W = 8;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } mode_e;

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Any non-BCD or out-of-range code snaps to 00 on its next increment.
  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q,
                                                input int unsigned modv);
    logic [3:0]  tens;
    logic [3:0]  units;
    int unsigned val;
    tens  = q[7:4];
    units = q[3:0];
    val   = 32'(tens) * 10 + 32'(units);
    if (tens > 4'd9 || units > 4'd9 || val >= modv - 1)
      return '0;
    else if (units == 4'd9)
      return {tens + 4'd1, 4'd0};
    else
      return {tens, units + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD mod-MOD counter; clr beats en, co flags the wrap this cycle.
module bcd_mod_cnt
  import exp10_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  localparam logic [BCD_W-1:0] LAST = to_bcd(MOD - 1);

  logic [BCD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = bcd_next(cnt_q, MOD);
  end

  always_ff @(posedge CLK) begin
    if (RST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q  = cnt_q;
  assign co = en && (cnt_q == LAST);

endmodule

// File: rtl/exp10_time_ctrl.sv
// Time-of-day controller: cascaded sec/min/hr BCD counters plus key-driven SET FSM.
// Define ALARM_EN to add the AH/AM alarm registers, their SET states and the ALM match.
module exp10_time_ctrl
  import exp10_pkg::*;
#(
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60,
  parameter int unsigned HR_MOD  = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             KEY_MODE,
  input  logic             KEY_INC,
  output logic [BCD_W-1:0] HH,
  output logic [BCD_W-1:0] MM,
  output logic [BCD_W-1:0] SS,
  output logic [2:0]       MODE,
  output logic             Co,
  output logic             ALM
);

  mode_e state_q, state_d;
  logic  co_q, co_d;
  logic  sec_en, min_en, hr_en, sec_clr;
  logic  sec_co, min_co, hr_co;
`ifdef ALARM_EN
  logic             ah_en, am_en;
  logic [BCD_W-1:0] ah_q, am_q;
  logic             alm_q, alm_d;
`endif

  always_comb begin
    state_d = state_q;
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hr_en   = 1'b0;
    sec_clr = 1'b0;
`ifdef ALARM_EN
    ah_en   = 1'b0;
    am_en   = 1'b0;
`endif
    // KEY_MODE always wins over KEY_INC; a RUN tick still lands on the mode-change cycle.
    case (state_q)
      RUN: begin
        sec_en = TICK;
        min_en = sec_co;
        hr_en  = min_co;
        if (KEY_MODE) state_d = SET_HR;
      end
      SET_HR: begin
        if (KEY_MODE) state_d = SET_MIN;
        else          hr_en   = KEY_INC;
      end
      SET_MIN: begin
        if (KEY_MODE) begin
`ifdef ALARM_EN
          state_d = SET_AHR;
`else
          state_d = RUN;
          sec_clr = 1'b1;
`endif
        end else begin
          min_en = KEY_INC;
        end
      end
`ifdef ALARM_EN
      SET_AHR: begin
        if (KEY_MODE) state_d = SET_AMIN;
        else          ah_en   = KEY_INC;
      end
      SET_AMIN: begin
        if (KEY_MODE) begin
          state_d = RUN;
          sec_clr = 1'b1;
        end else begin
          am_en = KEY_INC;
        end
      end
`endif
      default: state_d = RUN;
    endcase
    co_d = (state_q == RUN) && hr_co;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      co_q    <= co_d;
    end
  end

  bcd_mod_cnt #(.MOD(SEC_MOD)) u_sec (
    .CLK(CLK), .RST(RST), .en(sec_en), .clr(sec_clr), .q(SS), .co(sec_co)
  );
  bcd_mod_cnt #(.MOD(MIN_MOD)) u_min (
    .CLK(CLK), .RST(RST), .en(min_en), .clr(1'b0), .q(MM), .co(min_co)
  );
  bcd_mod_cnt #(.MOD(HR_MOD)) u_hr (
    .CLK(CLK), .RST(RST), .en(hr_en), .clr(1'b0), .q(HH), .co(hr_co)
  );

`ifdef ALARM_EN
  bcd_mod_cnt #(.MOD(HR_MOD)) u_ah (
    .CLK(CLK), .RST(RST), .en(ah_en), .clr(1'b0), .q(ah_q), .co()
  );
  bcd_mod_cnt #(.MOD(MIN_MOD)) u_am (
    .CLK(CLK), .RST(RST), .en(am_en), .clr(1'b0), .q(am_q), .co()
  );

  always_comb begin
    alm_d = (state_q == RUN) && (HH == ah_q) && (MM == am_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) alm_q <= 1'b0;
    else     alm_q <= alm_d;
  end

  assign ALM = alm_q;
`else
  assign ALM = 1'b0;
`endif

  assign MODE = state_q;
  assign Co   = co_q;

endmodule

// File: tb/tb_exp10_time_ctrl.sv
// Bench for exp10_time_ctrl (default build): integer time-of-day model plus directed checks.
module tb_exp10_time_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0;
  logic       KEY_MODE = 1'b0;
  logic       KEY_INC = 1'b0;
  logic [7:0] HH, MM, SS;
  logic [2:0] MODE;
  logic       Co, ALM;

  always #5 CLK = ~CLK;

  exp10_time_ctrl dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
    .HH(HH), .MM(MM), .SS(SS), .MODE(MODE), .Co(Co), .ALM(ALM)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: plain integers for the time, mode as 0=run, 1=set hour, 2=set minute.
  int m_hr, m_min, m_sec, m_mode;
  bit m_co;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_hr = 0; m_min = 0; m_sec = 0; m_mode = 0; m_co = 1'b0;
    end else begin
      m_co = 1'b0;
      if (m_mode == 0) begin
        if (TICK) begin
          m_sec = m_sec + 1;
          if (m_sec == 60) begin
            m_sec = 0;
            m_min = m_min + 1;
            if (m_min == 60) begin
              m_min = 0;
              m_hr  = m_hr + 1;
              if (m_hr == 24) begin
                m_hr = 0;
                m_co = 1'b1;
              end
            end
          end
        end
        if (KEY_MODE) m_mode = 1;
      end else if (m_mode == 1) begin
        if (KEY_MODE)     m_mode = 2;
        else if (KEY_INC) m_hr = (m_hr + 1) % 24;
      end else begin
        if (KEY_MODE) begin
          m_mode = 0;
          m_sec  = 0;
        end else if (KEY_INC) begin
          m_min = (m_min + 1) % 60;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_HH", 32'(HH), 32'(bcd(m_hr)));
      chk("model_MM", 32'(MM), 32'(bcd(m_min)));
      chk("model_SS", 32'(SS), 32'(bcd(m_sec)));
      chk("model_MODE", 32'(MODE), 32'(m_mode));
      chk("model_Co", 32'(Co), 32'(m_co));
      chk("model_ALM", 32'(ALM), 32'd0);
    end
  end

  task automatic drive(input bit t, input bit m, input bit i, input bit r);
    @(negedge CLK);
    TICK = t; KEY_MODE = m; KEY_INC = i; RST = r;
  endtask

  task automatic rep(input int n, input bit t, input bit m, input bit i);
    for (int k = 0; k < n; k++) drive(t, m, i, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({name, "_HH"}, 32'(HH), 32'(h));
    chk({name, "_MM"}, 32'(MM), 32'(m));
    chk({name, "_SS"}, 32'(SS), 32'(s));
  endtask

  logic [7:0] hr_seq [3];

  initial begin
    hr_seq[0] = 8'h23; hr_seq[1] = 8'h00; hr_seq[2] = 8'h01;

    // Reset held for two cycles
    @(posedge CLK);
    chk_en = 1'b1;
    drive(0, 0, 0, 1);
    idle();
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_MODE", 32'(MODE), 32'd0);
    chk("reset_Co", 32'(Co), 32'd0);

    // Preset 23:59:58 and roll the day over
    drive(0, 1, 0, 0);
    rep(23, 0, 0, 1);
    drive(0, 1, 0, 0);
    rep(59, 0, 0, 1);
    drive(0, 1, 0, 0);
    rep(58, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk_time("pre58", 8'h23, 8'h59, 8'h58);
    drive(1, 0, 0, 0);
    chk_time("pre59", 8'h23, 8'h59, 8'h59);
    chk("pre59_Co", 32'(Co), 32'd0);
    idle();
    chk_time("rollover", 8'h00, 8'h00, 8'h00);
    chk("rollover_Co", 32'(Co), 32'd1);
    idle();
    chk("after_rollover_Co", 32'(Co), 32'd0);

    // 09:09:59 + TICK -> 09:10:00
    drive(0, 1, 0, 0);
    rep(9, 0, 0, 1);
    drive(0, 1, 0, 0);
    rep(9, 0, 0, 1);
    drive(0, 1, 0, 0);
    rep(59, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk_time("t3_pre", 8'h09, 8'h09, 8'h59);
    idle();
    chk_time("t3_carry", 8'h09, 8'h10, 8'h00);

    // SET_HR increments with wrap while ticks are ignored
    rep(5, 1, 0, 0);
    drive(0, 1, 0, 0);
    idle();
    chk("t4_MODE", 32'(MODE), 32'd1);
    chk("t4_SS", 32'(SS), 32'h05);
    rep(13, 0, 0, 1);
    idle();
    chk("t4_HH22", 32'(HH), 32'h22);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0);
      drive(1, 0, 0, 0);
      chk_time("t4_inc", hr_seq[k], 8'h10, 8'h05);
    end
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    idle();
    chk("t4_exit_MODE", 32'(MODE), 32'd0);
    chk_time("t4_exit", 8'h01, 8'h10, 8'h00);

    // TICK together with KEY_MODE in RUN: both take effect
    drive(1, 1, 0, 0);
    idle();
    chk("tm_MODE", 32'(MODE), 32'd1);
    chk("tm_SS", 32'(SS), 32'h01);

    // KEY_MODE + KEY_INC in SET_HR: mode change only
    drive(0, 1, 1, 0);
    idle();
    chk("t5_MODE", 32'(MODE), 32'd2);
    chk("t5_HH", 32'(HH), 32'h01);
    rep(3, 0, 0, 1);
    idle();
    chk("t5_MM", 32'(MM), 32'h13);
    drive(0, 0, 0, 1);
    idle();
    chk_time("t5_rst", 8'h00, 8'h00, 8'h00);
    chk("t5_rst_MODE", 32'(MODE), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    end
    // Long runs of ticks with rare key activity to reach minute and hour carries
    for (int k = 0; k < 8000; k++) begin
      drive(1'b1, $urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0, 1'b0);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
